// File: rtl/act_pack_fifo.sv
// Packs signed Q1.7 activation bytes little-endian into 32-bit words and queues them in a small FIFO.
// A word is emitted when four bytes are collected or when a byte is marked last.
module act_pack_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_last_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_data_o,
  output logic [2:0]                   out_bytes_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    lane;
  logic [23:0]   pack;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] mem_data  [DEPTH];
  logic [2:0]  mem_bytes [DEPTH];

  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] word;
  logic [2:0]  word_bytes;

  // Ready depends only on registered occupancy, never on the consumer side.
  assign in_ready_o  = (count != FULL) && !rst_i;
  assign out_valid_o = (count != '0);
  assign accept      = in_valid_i && in_ready_o;
  assign push        = accept && (in_last_i || (lane == 2'd3));
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  // Lanes above the incoming byte are zero-filled for short (last) words.
  always_comb begin
    word = 32'd0;
    case (lane)
      2'd0:    word = {24'd0, in_data_i};
      2'd1:    word = {16'd0, in_data_i, pack[7:0]};
      2'd2:    word = {8'd0, in_data_i, pack[15:0]};
      default: word = {in_data_i, pack[23:0]};
    endcase
  end

  assign word_bytes = {1'b0, lane} + 3'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane <= 2'd0;
      pack <= 24'd0;
    end else if (accept) begin
      if (push) begin
        lane <= 2'd0;
        pack <= 24'd0;
      end else begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    pack[7:0]   <= in_data_i;
          2'd1:    pack[15:8]  <= in_data_i;
          default: pack[23:16] <= in_data_i;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is unreset; the output mux hides stale contents while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr]  <= word;
      mem_bytes[wr_ptr] <= word_bytes;
    end
  end

  assign out_data_o  = out_valid_o ? mem_data[rd_ptr]  : 32'd0;
  assign out_bytes_o = out_valid_o ? mem_bytes[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_act_pack_fifo.sv
// Self-checking bench for act_pack_fifo: fixed vector table plus a cycle model feeding a word scoreboard.
module tb_act_pack_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [7:0]    in_data_i = 8'd0;
  logic          in_last_i = 1'b0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_data_o;
  logic [2:0]    out_bytes_o;
  logic [CW-1:0] count_o;

  act_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_bytes_o (out_bytes_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
  } entry_t;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic [2:0]  ec;
  } vec_t;

  entry_t      sb[$];
  int          model_lane = 0;
  logic [31:0] model_pack = 32'd0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  vec_t        vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid_i  = v;
    in_data_i   = d;
    in_last_i   = l;
    out_ready_i = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] ed,
                             input logic [2:0] eb, input logic [2:0] ec);
    check({name, ".valid"}, 32'(out_valid_o), 32'(ev));
    check({name, ".data"},  out_data_o, ed);
    check({name, ".bytes"}, 32'(out_bytes_o), 32'(eb));
    check({name, ".count"}, 32'(count_o), 32'(ec));
  endtask

  // Compare against the model's pre-edge view, then advance the model across the edge.
  task automatic stepClock(output bit accepted);
    bit exp_rdy;
    bit exp_vld;
    exp_vld = (sb.size() != 0);
    exp_rdy = (sb.size() != DEPTH) && !rst_i;
    check("sb.count", 32'(count_o), 32'(sb.size()));
    check("sb.in_ready", 32'(in_ready_o), 32'(exp_rdy));
    check("sb.out_valid", 32'(out_valid_o), 32'(exp_vld));
    if (exp_vld) begin
      check("sb.head_data", out_data_o, sb[0].data);
      check("sb.head_bytes", 32'(out_bytes_o), 32'(sb[0].bytes));
    end else begin
      check("sb.idle_data", out_data_o, 32'd0);
      check("sb.idle_bytes", 32'(out_bytes_o), 32'd0);
    end
    accepted = in_valid_i && exp_rdy;
    if (rst_i) begin
      sb.delete();
      model_lane = 0;
      model_pack = 32'd0;
      accepted   = 1'b0;
    end else begin
      if (exp_vld && out_ready_i) void'(sb.pop_front());
      if (accepted) begin
        model_pack[model_lane*8 +: 8] = in_data_i;
        if (model_lane == 3 || in_last_i) begin
          sb.push_back('{data: model_pack, bytes: 3'(model_lane + 1)});
          model_pack = 32'd0;
          model_lane = 0;
        end else begin
          model_lane++;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string name);
    bit acc;
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      stepClock(acc);
      guard++;
    end
    check({name, ".drain_done"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx;
    int guard;

    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h44332211, 3'd4, 3'd1};
    vecs[5]  = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[6]  = '{1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[7]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 32'h00007F81, 3'd2, 3'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h00007F81, 3'd2, 3'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00007F81, 3'd2, 3'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00000005, 3'd1, 3'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[12] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[13] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[14] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[15] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4, 3'd1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 3'd1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0};

    $display("[TB] reset");
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("reset", 1'b0, 32'd0, 3'd0, 3'd0);
    check("reset.in_ready", 32'(in_ready_o), 32'd0);
    stepClock(acc);
    rst_i = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].ec);
      stepClock(acc);
    end

    $display("[TB] backpressure to full");
    idx = 0;
    guard = 0;
    while (idx < 4 * DEPTH && guard < 200) begin
      applyStimulus(1'b1, 8'(idx), 1'b0, 1'b0);
      stepClock(acc);
      if (acc) idx++;
      guard++;
    end
    check("full.bytes_accepted", 32'(idx), 32'(4 * DEPTH));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      checkOutput("full.hold", 1'b1, 32'h03020100, 3'd4, 3'(DEPTH));
      check("full.in_ready", 32'(in_ready_o), 32'd0);
      stepClock(acc);
    end
    drain("full");

    $display("[TB] simultaneous push and pop across wrap");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      stepClock(acc);
    end
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 3; b++) begin
        applyStimulus(1'b1, 8'h60 + 8'(w * 4 + b), 1'b0, 1'b0);
        stepClock(acc);
      end
      applyStimulus(1'b1, 8'h60 + 8'(w * 4 + 3), 1'b0, 1'b1);
      check("pushpop.count_before", 32'(count_o), 32'd2);
      stepClock(acc);
      check("pushpop.count_after", 32'(count_o), 32'd2);
    end
    drain("pushpop");

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      stepClock(acc);
    end
    check("midrst.count_before", 32'(count_o), 32'd2);
    rst_i = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    stepClock(acc);
    rst_i = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("midrst.after", 1'b0, 32'd0, 3'd0, 3'd0);
    check("midrst.in_ready", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      stepClock(acc);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("midrst.word", 1'b1, 32'hA3A2A1A0, 3'd4, 3'd1);
    stepClock(acc);
    drain("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
